audio_adc_deserializer: RTL and testbench

Captures the codec ADC serial stream (I2S, left-justified after a one-BCLK delay) in the system clock domain and converts it to parallel 16-bit left, right and mono samples. Sits directly upstream of the audio-input PIO: `sample_mono` drives the PIO's 16-bit `in_port`, and `sample_valid` marks each new stereo frame. The codec pins are asynchronous to `clk` and are oversampled; no BCLK-domain logic exists.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 48 ++++
 rtl/audio_adc_deserializer.sv | 209 ++++++++++++++++++++
 tb/tb_audio_adc_deserializer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared types and constants for the codec ADC deserializer:
//             FSM state encoding, default sample width, channel encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 16;

    // Channel encoding follows the LRCK level: low = left, high = right.
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sync_edge_detect
//  Purpose  : Synchronizes one asynchronous pin into clk and reports its
//             registered level together with rising/falling edge pulses.
//             sync, rise and fall are all aligned: SYNC_STAGES + 1 cycles
//             after the pin changes.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronizer chain plus one history flop; edges are registered so the
    // reported level (prev_q) is the value seen at the detected edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
            prev_q  <= chain_q[SYNC_STAGES-1];
            rise_q  <= chain_q[SYNC_STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign sync = prev_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/audio_adc_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : audio_adc_deserializer
//  Purpose  : Oversamples the codec I2S ADC pins in the clk domain and
//             produces coherent 16-bit left/right/mono samples with a
//             one-cycle valid strobe per complete stereo frame.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_adc_deserializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    aud_bclk,
    input  logic                    aud_adclrck,
    input  logic                    aud_adcdat,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic [SAMPLE_WIDTH-1:0] sample_mono,
    output logic                    sample_valid,
    output logic                    frame_error
);

    localparam int             CW         = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0]  c_cnt_full = CW'(SAMPLE_WIDTH);

    // Synchronized pin events
    logic w_bclk_rise;
    logic w_lr_rise;
    logic w_lr_fall;
    logic w_dat;
    logic w_unused_bclk_sync;
    logic w_unused_bclk_fall;
    logic w_unused_lr_sync;
    logic w_unused_dat_rise;
    logic w_unused_dat_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk   (clk),
        .reset (reset),
        .din   (aud_bclk),
        .sync  (w_unused_bclk_sync),
        .rise  (w_bclk_rise),
        .fall  (w_unused_bclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk   (clk),
        .reset (reset),
        .din   (aud_adclrck),
        .sync  (w_unused_lr_sync),
        .rise  (w_lr_rise),
        .fall  (w_lr_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk   (clk),
        .reset (reset),
        .din   (aud_adcdat),
        .sync  (w_dat),
        .rise  (w_unused_dat_rise),
        .fall  (w_unused_dat_fall)
    );

    // State and datapath registers
    state_t                  state_q,    state_d;
    logic                    chan_q,     chan_d;
    logic [CW-1:0]           cnt_q,      cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q,    shift_d;
    logic [SAMPLE_WIDTH-1:0] pend_q,     pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [SAMPLE_WIDTH-1:0] left_q,     left_d;
    logic [SAMPLE_WIDTH-1:0] right_q,    right_d;
    logic [SAMPLE_WIDTH-1:0] mono_q,     mono_d;
    logic                    valid_q,    valid_d;
    logic                    ferr_q,     ferr_d;

    logic                    w_lr_edge;
    logic                    w_lr_chan;
    logic [CW-1:0]           w_cnt_inc;
    logic [SAMPLE_WIDTH-1:0] w_shift_next;
    logic [SAMPLE_WIDTH:0]   w_sum;
    logic [SAMPLE_WIDTH-1:0] w_mono;

    assign w_lr_edge    = w_lr_rise | w_lr_fall;
    // Channel comes from the edge direction so a missed edge cannot swap L/R.
    assign w_lr_chan    = w_lr_rise ? RIGHT : LEFT;
    assign w_cnt_inc    = cnt_q + CW'(1);
    assign w_shift_next = {shift_q[SAMPLE_WIDTH-2:0], w_dat};
    // Sign-extended sum keeps the carry, so dropping the LSB cannot overflow.
    assign w_sum        = {pend_q[SAMPLE_WIDTH-1], pend_q}
                        + {w_shift_next[SAMPLE_WIDTH-1], w_shift_next};
    assign w_mono       = w_sum[SAMPLE_WIDTH:1];

    // Next-state: LRCK edges take priority; a coincident BCLK rise is the
    // I2S delay bit of the new slot, so SKIP is bypassed in that case.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        left_d     = left_q;
        right_d    = right_q;
        mono_d     = mono_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_lr_fall) begin
                    chan_d     = LEFT;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = w_bclk_rise ? SHIFT : SKIP;
                end
            end

            SKIP, SHIFT: begin
                if (w_lr_edge) begin
                    // Slot cut short: drop the partial word and any pending left.
                    ferr_d     = 1'b1;
                    chan_d     = w_lr_chan;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = w_bclk_rise ? SHIFT : SKIP;
                end else if (w_bclk_rise) begin
                    if (state_q == SKIP) begin
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        shift_d = w_shift_next;
                        cnt_d   = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_full) begin
                            state_d = WAIT;
                            if (chan_q == LEFT) begin
                                pend_d     = w_shift_next;
                                pend_vld_d = 1'b1;
                            end else begin
                                if (pend_vld_q) begin
                                    left_d  = pend_q;
                                    right_d = w_shift_next;
                                    mono_d  = w_mono;
                                    valid_d = 1'b1;
                                end
                                pend_vld_d = 1'b0;
                            end
                        end
                    end
                end
            end

            WAIT: begin
                if (w_lr_edge) begin
                    chan_d  = w_lr_chan;
                    cnt_d   = '0;
                    if (w_lr_fall) begin
                        pend_vld_d = 1'b0;
                    end
                    state_d = w_bclk_rise ? SHIFT : SKIP;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            chan_q     <= LEFT;
            cnt_q      <= '0;
            shift_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            mono_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            left_q     <= left_d;
            right_q    <= right_d;
            mono_q     <= mono_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign sample_left  = left_q;
    assign sample_right = right_q;
    assign sample_mono  = mono_q;
    assign sample_valid = valid_q;
    assign frame_error  = ferr_q;

endmodule : audio_adc_deserializer
`default_nettype wire

// File: tb/tb_audio_adc_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_audio_adc_deserializer
//  Purpose  : Self-checking bench for audio_adc_deserializer. Drives an I2S
//             codec stream, queues expected frames, compares received frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_adc_deserializer;

    localparam int HALF = 160;   // BCLK half period in ns (~3.1 MHz)

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] m;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic [15:0] sample_mono;
    logic        sample_valid;
    logic        frame_error;

    frame_t exp_q[$];
    frame_t rx_q[$];
    int     rx_cyc_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     ferr_cnt     = 0;
    int     cyc          = 0;
    int     arm_cyc      = 0;

    always #10 clk = ~clk;

    audio_adc_deserializer #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_mono  (sample_mono),
        .sample_valid (sample_valid),
        .frame_error  (frame_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output frame and frame-error pulse away from the active edge
    always @(negedge clk) begin
        if (sample_valid) begin
            rx_q.push_back({sample_left, sample_right, sample_mono});
            rx_cyc_q.push_back(cyc);
        end
        if (frame_error) ferr_cnt = ferr_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    function automatic frame_t model(input logic [15:0] l, input logic [15:0] r);
        int a;
        int b;
        int s;
        frame_t f;
        a = $signed(l);
        b = $signed(r);
        s = (a + b) >>> 1;
        f.l = l;
        f.r = r;
        f.m = s[15:0];
        return f;
    endfunction

    task automatic bclk_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #HALF aud_bclk = 1'b1;
            #HALF aud_bclk = 1'b0;
        end
    endtask

    // One slot: LRCK changes 'lead' ns before the delay-bit rise, then nd data
    // bits MSB first, then padding up to ncyc BCLK periods in total.
    task automatic send_slot(input logic ch, input logic [15:0] data, input int nd,
                             input int ncyc, input int lead, input bit arm);
        aud_adcdat = 1'b0;
        #(HALF - lead);
        aud_adclrck = ch;
        #(lead);
        aud_bclk = 1'b1;
        #HALF aud_bclk = 1'b0;
        for (int i = 0; i < ncyc - 1; i++) begin
            aud_adcdat = (i < nd) ? data[15 - i] : 1'b0;
            #HALF aud_bclk = 1'b1;
            if (arm && i == nd - 1) arm_cyc = cyc;
            #HALF aud_bclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int ncyc, input int lead, input bit arm);
        exp_q.push_back(model(l, r));
        send_slot(1'b0, l, 16, ncyc, lead, 1'b0);
        send_slot(1'b1, r, 16, ncyc, lead, arm);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b1;
        aud_adcdat  = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if ({sample_left, sample_right, sample_mono} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_samples: got %h/%h/%h expected 0000/0000/0000",
                     sample_left, sample_right, sample_mono);
        end
        tests_run++;
        if ({sample_valid, frame_error} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_strobes: got valid=%b ferr=%b expected 0/0", sample_valid, frame_error);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 0 || ferr_cnt != 0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %0d frames %0d errors expected 0/0", rx_q.size(), ferr_cnt);
        end
    endtask

    task automatic test_nominal();
        frame_t e, g;
        int e0;
        e0 = ferr_cnt;
        send_frame(16'h1234, 16'h5678, 17, HALF, 1'b0);
        send_frame(16'h1234, 16'h5678, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != exp_q.size() || ferr_cnt != e0) begin
            tests_failed++;
            $display("FAIL nominal_count: got %0d frames %0d errors expected %0d frames 0 errors",
                     rx_q.size(), ferr_cnt - e0, exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL nominal_frame: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    task automatic test_extremes();
        frame_t e, g;
        send_frame(16'h8000, 16'h8000, 17, HALF, 1'b0);
        send_frame(16'h7FFF, 16'h8001, 17, HALF, 1'b0);
        send_frame(16'h7FFF, 16'h7FFF, 17, HALF, 1'b0);
        send_frame(16'h0001, 16'h0000, 17, HALF, 1'b0);
        send_frame(16'hFFFF, 16'h0000, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL extremes_count: got %0d frames expected %0d", rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL extremes_frame: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    task automatic test_short_slot();
        frame_t e, g, prev;
        int e0;
        prev = model(16'hFFFF, 16'h0000);
        e0   = ferr_cnt;
        send_slot(1'b0, 16'hAAAA, 10, 11, HALF, 1'b0);
        send_slot(1'b1, 16'h1111, 16, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (ferr_cnt - e0 != 1 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL short_slot_error: got %0d errors %0d frames expected 1 error 0 frames",
                     ferr_cnt - e0, rx_q.size());
        end
        tests_run++;
        if ({sample_left, sample_right, sample_mono} !== prev) begin
            tests_failed++;
            $display("FAIL short_slot_hold: got %h/%h/%h expected %h/%h/%h",
                     sample_left, sample_right, sample_mono, prev.l, prev.r, prev.m);
        end
        send_frame(16'h0F0F, 16'hF0F0, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 1 || ferr_cnt - e0 != 1) begin
            tests_failed++;
            $display("FAIL short_slot_recover_count: got %0d frames %0d errors expected 1/1",
                     rx_q.size(), ferr_cnt - e0);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL short_slot_recover: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    task automatic test_reset_mid();
        frame_t e, g;
        send_slot(1'b0, 16'h1357, 16, 17, HALF, 1'b0);
        aud_adclrck = 1'b1;
        bclk_cycles(6);
        reset = 1'b1;
        bclk_cycles(6);
        aud_adclrck = 1'b0;
        bclk_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({sample_left, sample_right, sample_mono, sample_valid} !== 49'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h/%h/%h v=%b expected 0000/0000/0000 v=0",
                     sample_left, sample_right, sample_mono, sample_valid);
        end
        bclk_cycles(10);
        send_slot(1'b1, 16'h2468, 16, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_valid: got %0d frames expected 0", rx_q.size());
        end
        rx_q.delete(); rx_cyc_q.delete();
        send_frame(16'hC001, 16'h4002, 17, HALF, 1'b0);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 1) begin
            tests_failed++;
            $display("FAIL reset_mid_first_frame_count: got %0d frames expected 1", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_first_frame: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    task automatic test_long_slots();
        frame_t e, g;
        int c, e0;
        e0 = ferr_cnt;
        send_frame(16'h1234, 16'h5678, 32, HALF, 1'b1);
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 1 || ferr_cnt != e0) begin
            tests_failed++;
            $display("FAIL long_slot_count: got %0d frames %0d errors expected 1/0", rx_q.size(), ferr_cnt - e0);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); c = rx_cyc_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL long_slot_frame: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
            tests_run++;
            if (c - arm_cyc != 4) begin
                tests_failed++;
                $display("FAIL long_slot_latency: got %0d cycles expected 4", c - arm_cyc);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    task automatic test_phase_sweep();
        frame_t e, g;
        int e0;
        e0 = ferr_cnt;
        for (int i = 0; i < 10; i++) begin
            send_frame(16'hA5C3, 16'h3C5A, 17, 3 + 4 * i, 1'b0);
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 10 || ferr_cnt != e0) begin
            tests_failed++;
            $display("FAIL phase_sweep_count: got %0d frames %0d errors expected 10/0", rx_q.size(), ferr_cnt - e0);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rx_cyc_q.pop_front());
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL phase_sweep_frame: got %h/%h/%h expected %h/%h/%h", g.l, g.r, g.m, e.l, e.r, e.m);
            end
        end
        exp_q.delete(); rx_q.delete(); rx_cyc_q.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_extremes();
        test_short_slot();
        test_reset_mid();
        test_long_slots();
        test_phase_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_audio_adc_deserializer
`default_nettype wire
